// File: rtl/dds_pkg.sv
// Shared DDS definitions: sample format, DAC mode encodings, FSM state type and
// the offset-binary helper used by sample consumers.
package dds_pkg;

    localparam int unsigned SAMPLE_W = 6;
    localparam int unsigned MIDSCALE = 32;

    localparam logic DAC_MODE_PWM = 1'b0;
    localparam logic DAC_MODE_SD  = 1'b1;

    typedef enum logic {
        StIdle,
        StRun
    } dac_state_e;

    // Signed two's-complement to offset binary: invert the MSB.
    function automatic logic [SAMPLE_W-1:0] to_offset_binary(input logic [SAMPLE_W-1:0] s);
        return {~s[SAMPLE_W-1], s[SAMPLE_W-2:0]};
    endfunction

endpackage

// File: rtl/dds_tick_prescaler.sv
// Programmable tick prescaler: one tick every div_i+1 enabled clocks, with a
// synchronous clear. The >= compare lets a lowered divisor take effect at once.
module dds_tick_prescaler #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick_o = en_i && (cnt_q >= div_i);
        cnt_d  = cnt_q;
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dds_pwm_dac.sv
// DDS output DAC: converts signed samples to a 1-bit PWM or first-order
// sigma-delta pulse stream. Sigma-delta is built only with DDS_DAC_SIGMA_DELTA_EN.
module dds_pwm_dac
    import dds_pkg::*;
#(
    parameter int unsigned WIDTH = SAMPLE_W,
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_in,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             sample_valid_in,
    input  logic [DIV_W-1:0] div_in,
    input  logic             mode_in,
    output logic             pwm_out,
    output logic             sample_req_out
);

    localparam logic [WIDTH-1:0] MidDuty = WIDTH'(1) << (WIDTH - 1);
    localparam logic [WIDTH-1:0] CntMax  = {WIDTH{1'b1}};

    dac_state_e       state_q, state_d;
    logic             run, run_n, tick, wrap;
    logic [WIDTH-1:0] sample_u;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             pwm_q, pwm_d;
    logic             req_q, req_d;
    logic             mode_q;
    logic             sd_bit;

    if (WIDTH == SAMPLE_W) begin : g_pkg_conv
        assign sample_u = to_offset_binary(sample_in);
    end else begin : g_gen_conv
        assign sample_u = sample_in ^ MidDuty;
    end

    // FSM: state register, next state, outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = enable_in ? StRun : StIdle;
    end

    always_comb begin
        run   = (state_q == StRun) && enable_in;
        run_n = !run;
    end

    dds_tick_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (run),
        .clr_i  (run_n),
        .div_i  (div_in),
        .tick_o (tick)
    );

    assign wrap = tick && (cnt_q == CntMax);

`ifdef DDS_DAC_SIGMA_DELTA_EN
    logic             mode_d;
    logic             sd_carry;
    logic [WIDTH-1:0] acc_sum;
    logic [WIDTH-1:0] acc_q, acc_d;

    always_comb begin
        {sd_carry, acc_sum} = {1'b0, acc_q} + {1'b0, duty_q};
        mode_d = mode_q;
        if (run_n || wrap) begin
            mode_d = mode_in;
        end
        acc_d = acc_q;
        if (run_n) begin
            acc_d = '0;
        end else if (tick && (mode_q == DAC_MODE_SD)) begin
            acc_d = acc_sum;
        end
        // Carry is the pulse; hold the last pulse between ticks.
        sd_bit = tick ? sd_carry : pwm_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= DAC_MODE_PWM;
            acc_q  <= '0;
        end else begin
            mode_q <= mode_d;
            acc_q  <= acc_d;
        end
    end
`else
    logic unused_mode;
    assign unused_mode = mode_in;
    assign mode_q      = DAC_MODE_PWM;
    assign sd_bit      = 1'b0;
`endif

    always_comb begin
        pending_d = pending_q;
        if (!enable_in) begin
            pending_d = MidDuty;
        end else if (sample_valid_in) begin
            pending_d = sample_u;
        end

        duty_d = duty_q;
        cnt_d  = cnt_q;
        pwm_d  = pwm_q;
        req_d  = 1'b0;
        if (run_n) begin
            duty_d = MidDuty;
            cnt_d  = '0;
            pwm_d  = 1'b0;
        end else begin
            // Duty only changes at the period boundary; a same-clock capture waits.
            if (wrap) begin
                duty_d = pending_q;
            end
            if (tick) begin
                cnt_d = cnt_q + WIDTH'(1);
            end
            pwm_d = (mode_q == DAC_MODE_SD) ? sd_bit : (cnt_q < duty_q);
            req_d = wrap;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= MidDuty;
            duty_q    <= MidDuty;
            cnt_q     <= '0;
            pwm_q     <= 1'b0;
            req_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            duty_q    <= duty_d;
            cnt_q     <= cnt_d;
            pwm_q     <= pwm_d;
            req_q     <= req_d;
        end
    end

    assign pwm_out        = pwm_q;
    assign sample_req_out = req_q;

endmodule

// File: tb/tb_dds_pwm_dac.sv
// Scoreboard bench for dds_pwm_dac: per-clock expected outputs from a behavioural
// model are queued by the driver and checked by an independent monitor.
module tb_dds_pwm_dac;

    localparam int unsigned WIDTH = 6;
    localparam int unsigned DIV_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enable_in;
    logic [WIDTH-1:0] sample_in;
    logic             sample_valid_in;
    logic [DIV_W-1:0] div_in;
    logic             mode_in;
    logic             pwm_out;
    logic             sample_req_out;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [1:0]  exp_q[$];

    // Model state: tick count since run start, run clocks, running SD sum.
    int     m_pending, m_duty;
    bit     m_mode, m_pwm, m_req, m_prev_en;
    longint m_n, m_r, m_total;

    always #5 clk = ~clk;

    dds_pwm_dac #(
        .WIDTH (WIDTH),
        .DIV_W (DIV_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable_in       (enable_in),
        .sample_in       (sample_in),
        .sample_valid_in (sample_valid_in),
        .div_in          (div_in),
        .mode_in         (mode_in),
        .pwm_out         (pwm_out),
        .sample_req_out  (sample_req_out)
    );

    function automatic bit eff_mode(input bit m);
`ifdef DDS_DAC_SIGMA_DELTA_EN
        return m;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_pending = 32;
        m_duty    = 32;
        m_mode    = 1'b0;
        m_pwm     = 1'b0;
        m_req     = 1'b0;
        m_prev_en = 1'b0;
        m_n       = 0;
        m_r       = 0;
        m_total   = 0;
    endtask

    // Advance the model across the coming rising edge using the current inputs.
    task automatic model_step();
        bit     run, tick, wrap, nxt;
        longint ph, old;
        if (!enable_in) begin
            model_reset();
            m_mode = eff_mode(mode_in);
        end else begin
            run  = m_prev_en;
            ph   = m_n % 64;
            tick = run && ((m_r % (longint'(div_in) + 1)) == longint'(div_in));
            wrap = tick && (ph == 63);
            if (!run) begin
                nxt = 1'b0;
            end else if (m_mode) begin
                nxt = m_pwm;
                if (tick) begin
                    old     = m_total;
                    m_total = m_total + m_duty;
                    nxt     = (m_total / 64) != (old / 64);
                end
            end else begin
                nxt = ph < m_duty;
            end
            m_pwm = nxt;
            m_req = wrap;
            if (!run || wrap) m_mode = eff_mode(mode_in);
            if (wrap) m_duty = m_pending;
            if (sample_valid_in) m_pending = int'($signed(sample_in)) + 32;
            if (tick) m_n++;
            if (run) m_r++;
            m_prev_en = 1'b1;
        end
    endtask

    task automatic cyc(input bit en, input bit v, input int s, input bit m);
        @(negedge clk);
        enable_in       = en;
        sample_valid_in = v;
        sample_in       = s[WIDTH-1:0];
        mode_in         = m;
        model_step();
        exp_q.push_back({m_pwm, m_req});
    endtask

    task automatic idle(input int n, input int d);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            enable_in       = 1'b0;
            sample_valid_in = 1'b0;
            div_in          = d[DIV_W-1:0];
            mode_in         = 1'b0;
            model_step();
            exp_q.push_back({m_pwm, m_req});
        end
    endtask

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Monitor: the DUT presents a registered output every clock.
    always @(posedge clk) begin
        logic [1:0] e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({pwm_out, sample_req_out} !== e) begin
                errors++;
                $display("FAIL out_stream t=%0t: got pwm=%0b req=%0b expected pwm=%0b req=%0b",
                         $time, pwm_out, sample_req_out, e[1], e[0]);
            end
        end
    end

    initial begin
        rst_n           = 1'b1;
        enable_in       = 1'b0;
        sample_valid_in = 1'b0;
        sample_in       = '0;
        div_in          = '0;
        mode_in         = 1'b0;
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        check("reset_pwm", int'(pwm_out), 0);
        check("reset_req", int'(sample_req_out), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Midscale, then full-scale low/high PWM.
        repeat (192) cyc(1'b1, 1'b1, 0, 1'b0);
        repeat (128) cyc(1'b1, 1'b1, -32, 1'b0);
        repeat (128) cyc(1'b1, 1'b1, 31, 1'b0);

        // Prescaled period of 256 clocks.
        idle(2, 3);
        repeat (520) cyc(1'b1, 1'b1, 0, 1'b0);

        // Two captures in one period: the last wins.
        idle(2, 0);
        repeat (64) cyc(1'b1, 1'b0, 0, 1'b0);
        for (int i = 0; i < 64; i++) cyc(1'b1, (i == 10) || (i == 40), (i == 10) ? -16 : 16, 1'b0);
        repeat (128) cyc(1'b1, 1'b0, 0, 1'b0);

        // Sigma-delta requests (PWM expected when the option is not built).
        idle(2, 0);
        repeat (192) cyc(1'b1, 1'b1, 0, 1'b1);
        repeat (192) cyc(1'b1, 1'b1, 31, 1'b1);
        repeat (128) cyc(1'b1, 1'b1, -20, 1'b0);

        // Drop enable mid-period at count 20, then restart.
        idle(1, 2);
        for (int k = 0; k < 2000 && (m_n % 64) != 20; k++) cyc(1'b1, 1'b1, 5, 1'b0);
        idle(3, 2);
        repeat (200) cyc(1'b1, 1'b1, -5, 1'b0);

        // Asynchronous reset while the output is high.
        idle(1, 0);
        for (int k = 0; k < 300 && !m_pwm; k++) cyc(1'b1, 1'b1, 31, 1'b0);
        check("pwm_high_before_reset", int'(m_pwm), 1);
        @(negedge clk);
        #2;
        enable_in = 1'b0;
        mode_in   = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("async_reset_pwm", int'(pwm_out), 0);
        check("async_reset_req", int'(sample_req_out), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic with occasional disables that may change the divisor.
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 199) == 0) begin
                idle(int'($urandom_range(1, 3)), int'($urandom_range(0, 3)));
            end else begin
                cyc(1'b1, $urandom_range(0, 3) == 0, int'($urandom_range(0, 63)) - 32,
                    1'($urandom_range(0, 1)));
            end
        end

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dds_pwm_dac.md
# dds_pwm_dac

Output DAC stage for the DDS. It sits directly downstream of the DDS top and consumes its 6-bit signed amplitude-scaled sample (`finwave_out`). It converts each sample to a 1-bit pulse stream for an off-chip RC filter, using either a 64-step PWM or a first-order sigma-delta modulator. A programmable prescaler sets the modulator tick rate, and a per-period request strobe paces the sample source.

## Interface
- `WIDTH`, 6, sample width; the counter and accumulator are WIDTH bits wide.
- `DIV_W`, 8, prescaler width.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `enable_in` in 1: run enable. Low holds the datapath cleared.
- `sample_in` in WIDTH: signed two's-complement sample from the DDS.
- `sample_valid_in` in 1: qualifies `sample_in` for capture.
- `div_in` in DIV_W: prescaler. One tick every `div_in+1` clocks.
- `mode_in` in 1: 0 = PWM, 1 = sigma-delta.
- `pwm_out` in/out: out 1, registered 1-bit DAC output.
- `sample_req_out` out 1: one-clock pulse at each period boundary.

## Operation
- **Offset conversion:** `u = sample_in ^ 2^(WIDTH-1)` (invert MSB). This maps -32..31 to 0..63.
- **Capture:** any clock with `sample_valid_in=1` and `enable_in=1` loads `u` into `pending_r`. If several captures occur within one period, the last one wins.
- **Prescaler:**
  - `div_cnt_r` increments each clock.
  - When `div_cnt_r >= div_in`, the prescaler asserts `tick` and `div_cnt_r` clears to 0.
  - `div_in=0` gives a tick on every clock.
  - The `>=` comparison makes a mid-count `div_in` decrease take effect at once.
- **Period counter:**
  - `cnt_r` (WIDTH bits) advances on each tick.
  - On a tick with `cnt_r==63`, it wraps to 0. At that wrap, `duty_r <= pending_r`, `mode_r <= mode_in`, and `sample_req_out` pulses for exactly one clock.
  - Duty and mode change only at this boundary.
- **PWM mode (`mode_r=0`):** every clock, `pwm_out <= (cnt_r < duty_r)`.
  - Duty 0 gives constant low.
  - Duty 63 gives 63 high ticks out of 64.
- **Sigma-delta mode (`mode_r=1`):**
  - On each tick, `{carry, acc_r} <= acc_r + duty_r` (WIDTH+1-bit sum), and `pwm_out <= carry`.
  - Between ticks, `pwm_out` holds its value.
  - `cnt_r` keeps running so `sample_req_out` cadence is identical in both modes.
- **States:** IDLE (`enable_in=0`) and RUN.
  - IDLE → RUN on `enable_in` rising. The first tick occurs `div_in+1` clocks later.
  - RUN → IDLE on `enable_in=0` at any clock, including mid-period. Taking this transition synchronously clears `div_cnt_r`, `cnt_r`, `acc_r` and `pwm_out`, sets `duty_r` and `pending_r` to 32, and drops `sample_req_out`.
  - `mode_r` loads `mode_in` while in IDLE.

## Timing
- Reset values:
  - `pwm_out=0`, `sample_req_out=0`.
  - `cnt_r=0`, `div_cnt_r=0`, `acc_r=0`.
  - `duty_r=32`, `pending_r=32` (midscale, sample 0).
  - `mode_r=0`.
- Sample-to-output latency: a captured sample reaches `duty_r` at the next wrap and affects `pwm_out` one clock later. Worst case is `64*(div_in+1)+1` clocks.
- PWM period is `64*(div_in+1)` clocks. `sample_req_out` has the same period.
- The `sample_req_out` pulse is coincident with the clock on which `duty_r` updates. A source that responds with `sample_valid_in` one clock later is captured for the following period.
- Capture and wrap in the same clock: `duty_r` takes the old `pending_r`, and the new sample lands in `pending_r` for the next period.
- Reset mid-operation: asynchronous return to reset values. No glitch requirement beyond registered outputs.

## Configuration
- `DDS_DAC_SIGMA_DELTA_EN` defined: sigma-delta path and `acc_r` are built, and `mode_in` is honoured.
- Not defined: `acc_r` is not built. `mode_in` is ignored and `mode_r` is tied to 0, so the block is PWM only. The port list is unchanged.

## Structure
- Shared package `dds_pkg`:
  - `SAMPLE_W=6`, `MIDSCALE=32`.
  - Mode constants `DAC_MODE_PWM=1'b0`, `DAC_MODE_SD=1'b1`.
  - An offset-binary conversion function reused by any other sample consumers.
- One sub-module, `dds_tick_prescaler` (DIV_W counter, `>=` compare, tick output, sync clear). It is natural to factor out for reuse by the accumulator's enable path.

## Test plan
- Reset, `enable_in=1`, `div_in=0`, `sample_in=0` held valid, PWM → after the first wrap, 32 of every 64 clocks high, and `sample_req_out` every 64 clocks.
- `sample_in=-32` → `pwm_out` constant 0. `sample_in=31` → 63 high / 1 low per 64 clocks. The new duty appears only after the wrap following capture.
- `div_in=3`, `sample_in=0` → period 256 clocks, each high/low level lasting a multiple of 4 clocks, `sample_req_out` spacing 256.
- Two valids in one period (`-16` then `+16`) → next period duty is 48 (high 48 ticks).
- With `DDS_DAC_SIGMA_DELTA_EN`, `mode_in=1`, `sample_in=0`, `div_in=0` → after the wrap, `pwm_out` alternates 0,1,0,1. `sample_in=31` → 63 ones per 64 clocks.
- `enable_in` dropped at `cnt_r=20` → next clock `pwm_out=0`, `cnt_r=0`. Re-enable → the first tick comes `div_in+1` clocks later and duty restarts at 32. Async `rst_n` pulse mid-period → immediate reset values.
